// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid entry, flush and stall counter.
// Latency 1 cycle; with SKID_EN ready_out is registered and one extra beat lands in the skid entry.
module pipe_stage_reg #(
    parameter int          DATA_W         = 160,
    parameter int unsigned SKID_EN        = 1,
    parameter int unsigned CLEAR_ON_FLUSH = 1,
    parameter int          CNT_W          = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ready_in,
    input  logic              flush_in,
    input  logic              stall_clr_in,
    output logic [CNT_W-1:0]  stall_cnt_out
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_q,  main_d;
    logic [DATA_W-1:0]   skid_q,  skid_d;
    logic                rdy_q,   rdy_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic accept;
    logic drain;
    logic stall;

    assign valid_out     = (state_q != ST_EMPTY);
    assign data_out      = main_q;
    assign stall_cnt_out = stall_cnt_q;

    // Skid mode breaks the ready_in -> ready_out path with a flop.
    assign ready_out = (SKID_EN != 0) ? rdy_q : (~valid_out | ready_in);

    assign accept = valid_in & ready_out;
    assign drain  = valid_out & ready_in;
    assign stall  = valid_out & ~ready_in;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (SKID_EN != 0) begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = data_in;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && drain) begin
                        main_d = data_in;
                    end else if (accept) begin
                        skid_d  = data_in;
                        state_d = ST_SKID;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    // ready_out is low here, so only the skid entry can move forward.
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end else begin
            if (accept) begin
                main_d  = data_in;
                state_d = ST_FULL;
            end else if (drain) begin
                state_d = ST_EMPTY;
            end
        end

        // A same-cycle drain has already been seen downstream; only held entries die.
        if (flush_in) begin
            state_d = ST_EMPTY;
            if (CLEAR_ON_FLUSH != 0) begin
                main_d = '0;
                skid_d = '0;
            end else begin
                main_d = main_q;
                skid_d = skid_q;
            end
        end

        rdy_d = (state_d != ST_SKID);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr_in) begin
            stall_cnt_d = '0;
        end else if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            rdy_q       <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            rdy_q       <= rdy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: two skid-mode stages (clear / keep on flush) and one non-skid stage.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    // shared stimulus for dut_a and dut_b
    logic        vld_i, rdy_i, flush, clr;
    logic [31:0] dat_i;
    logic        rdy_a, vld_a, rdy_b, vld_b;
    logic [31:0] dat_a, dat_b;
    logic [15:0] cnt_a;
    logic [2:0]  cnt_b;
    // stimulus for dut_c
    logic        c_vld_i, c_rdy_i, c_flush, c_clr;
    logic [31:0] c_dat_i;
    logic        c_rdy_o, c_vld_o;
    logic [31:0] c_dat_o;
    logic [2:0]  c_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_reg #(.DATA_W(32), .SKID_EN(1), .CLEAR_ON_FLUSH(1), .CNT_W(16)) dut_a (
        .clk_in(clk), .rst_in(rst), .valid_in(vld_i), .data_in(dat_i), .ready_out(rdy_a),
        .valid_out(vld_a), .data_out(dat_a), .ready_in(rdy_i), .flush_in(flush),
        .stall_clr_in(clr), .stall_cnt_out(cnt_a));

    pipe_stage_reg #(.DATA_W(32), .SKID_EN(1), .CLEAR_ON_FLUSH(0), .CNT_W(3)) dut_b (
        .clk_in(clk), .rst_in(rst), .valid_in(vld_i), .data_in(dat_i), .ready_out(rdy_b),
        .valid_out(vld_b), .data_out(dat_b), .ready_in(rdy_i), .flush_in(flush),
        .stall_clr_in(clr), .stall_cnt_out(cnt_b));

    pipe_stage_reg #(.DATA_W(32), .SKID_EN(0), .CLEAR_ON_FLUSH(1), .CNT_W(3)) dut_c (
        .clk_in(clk), .rst_in(rst), .valid_in(c_vld_i), .data_in(c_dat_i), .ready_out(c_rdy_o),
        .valid_out(c_vld_o), .data_out(c_dat_o), .ready_in(c_rdy_i), .flush_in(c_flush),
        .stall_clr_in(c_clr), .stall_cnt_out(c_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; vld_i = 1'b1; dat_i = 32'h55; rdy_i = 1'b1;
        c_vld_i = 1'b1; c_dat_i = 32'h55; c_rdy_i = 1'b1;
        tick(); tick();
        n_checks++;
        if (vld_a !== 1'b0 || rdy_a !== 1'b1 || dat_a !== 32'h0 || cnt_a !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_a: vld=%b rdy=%b dat=%h cnt=%0d, want 0 1 0 0", vld_a, rdy_a, dat_a, cnt_a);
        end
        n_checks++;
        if (c_vld_o !== 1'b0 || c_dat_o !== 32'h0 || c_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_c: vld=%b dat=%h cnt=%0d, want 0 0 0", c_vld_o, c_dat_o, c_cnt);
        end
        rst = 1'b0; vld_i = 1'b0; c_vld_i = 1'b0; c_rdy_i = 1'b0;
    endtask

    task automatic test_streaming();
        rdy_i = 1'b1; vld_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            dat_i = 32'(i);
            tick();
            n_checks++;
            if (vld_a !== 1'b1 || dat_a !== 32'(i) || rdy_a !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_%0d: vld=%b dat=%h rdy=%b, want 1 %h 1", i, vld_a, dat_a, rdy_a, i);
            end
        end
        vld_i = 1'b0;
        tick();
        n_checks++;
        if (vld_a !== 1'b0 || cnt_a !== 16'd0) begin
            n_fail++;
            $display("FAIL stream_end: vld=%b cnt=%0d, want 0 0", vld_a, cnt_a);
        end
    endtask

    task automatic test_skid();
        rdy_i = 1'b1; vld_i = 1'b1; dat_i = 32'hA;
        tick();
        rdy_i = 1'b0; dat_i = 32'hB;
        tick();
        n_checks++;
        if (rdy_a !== 1'b0 || vld_a !== 1'b1 || dat_a !== 32'hA || cnt_a !== 16'd1) begin
            n_fail++;
            $display("FAIL skid_enter: rdy=%b vld=%b dat=%h cnt=%0d, want 0 1 a 1", rdy_a, vld_a, dat_a, cnt_a);
        end
        dat_i = 32'hD;
        tick();
        n_checks++;
        if (rdy_a !== 1'b0 || dat_a !== 32'hA || cnt_a !== 16'd2) begin
            n_fail++;
            $display("FAIL skid_hold: rdy=%b dat=%h cnt=%0d, want 0 a 2", rdy_a, dat_a, cnt_a);
        end
        rdy_i = 1'b1; vld_i = 1'b0;
        tick();
        n_checks++;
        if (vld_a !== 1'b1 || dat_a !== 32'hB || rdy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL skid_second: vld=%b dat=%h rdy=%b, want 1 b 1", vld_a, dat_a, rdy_a);
        end
        tick();
        n_checks++;
        if (vld_a !== 1'b0 || cnt_a !== 16'd2 || cnt_b !== 3'd2) begin
            n_fail++;
            $display("FAIL skid_drained: vld=%b cnt_a=%0d cnt_b=%0d, want 0 2 2", vld_a, cnt_a, cnt_b);
        end
    endtask

    task automatic test_flush();
        rdy_i = 1'b1; vld_i = 1'b1; dat_i = 32'hA;
        tick();
        rdy_i = 1'b0; dat_i = 32'hB;
        tick();
        flush = 1'b1; dat_i = 32'hC;
        tick();
        n_checks++;
        if (vld_a !== 1'b0 || rdy_a !== 1'b1 || dat_a !== 32'h0 || cnt_a !== 16'd4) begin
            n_fail++;
            $display("FAIL flush_clear: vld=%b rdy=%b dat=%h cnt=%0d, want 0 1 0 4", vld_a, rdy_a, dat_a, cnt_a);
        end
        n_checks++;
        if (vld_b !== 1'b0 || rdy_b !== 1'b1 || dat_b !== 32'hA) begin
            n_fail++;
            $display("FAIL flush_keep: vld=%b rdy=%b dat=%h, want 0 1 a", vld_b, rdy_b, dat_b);
        end
        flush = 1'b0; vld_i = 1'b0; rdy_i = 1'b1;
        tick(); tick();
        n_checks++;
        if (vld_a !== 1'b0 || vld_b !== 1'b0 || dat_a === 32'hC || dat_b === 32'hC) begin
            n_fail++;
            $display("FAIL flush_no_c: vld_a=%b vld_b=%b dat_a=%h dat_b=%h, want 0 0 and no c", vld_a, vld_b, dat_a, dat_b);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if (cnt_a !== 16'd0 || cnt_b !== 3'd0) begin
            n_fail++;
            $display("FAIL cnt_clear: cnt_a=%0d cnt_b=%0d, want 0 0", cnt_a, cnt_b);
        end
    endtask

    task automatic test_saturation();
        rdy_i = 1'b1; vld_i = 1'b1; dat_i = 32'h5;
        tick();
        rdy_i = 1'b0; vld_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (cnt_b !== 3'd7 || cnt_a !== 16'd10) begin
            n_fail++;
            $display("FAIL saturate: cnt_b=%0d cnt_a=%0d, want 7 10", cnt_b, cnt_a);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if (cnt_b !== 3'd0 || cnt_a !== 16'd0) begin
            n_fail++;
            $display("FAIL clr_priority: cnt_b=%0d cnt_a=%0d, want 0 0", cnt_b, cnt_a);
        end
        tick();
        n_checks++;
        if (cnt_a !== 16'd1) begin
            n_fail++;
            $display("FAIL cnt_resume: cnt_a=%0d, want 1", cnt_a);
        end
        rdy_i = 1'b1;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        rdy_i = 1'b1; vld_i = 1'b1; dat_i = 32'hA;
        tick();
        rdy_i = 1'b0; dat_i = 32'hB;
        tick();
        rst = 1'b1; dat_i = 32'h77;
        tick();
        n_checks++;
        if (vld_a !== 1'b0 || rdy_a !== 1'b1 || dat_a !== 32'h0 || cnt_a !== 16'd0 || dat_b !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: vld=%b rdy=%b dat=%h cnt=%0d dat_b=%h, want 0 1 0 0 0", vld_a, rdy_a, dat_a, cnt_a, dat_b);
        end
        rst = 1'b0; rdy_i = 1'b1; dat_i = 32'h99;
        tick();
        vld_i = 1'b0;
        n_checks++;
        if (vld_a !== 1'b1 || dat_a !== 32'h99) begin
            n_fail++;
            $display("FAIL reset_first_beat: vld=%b dat=%h, want 1 99", vld_a, dat_a);
        end
        tick();
        n_checks++;
        if (vld_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drain: vld=%b, want 0", vld_a);
        end
    endtask

    task automatic test_noskid();
        c_vld_i = 1'b1; c_dat_i = 32'h11; c_rdy_i = 1'b1;
        tick();
        c_rdy_i = 1'b0; c_dat_i = 32'h22;
        #1;
        n_checks++;
        if (c_rdy_o !== 1'b0 || c_dat_o !== 32'h11) begin
            n_fail++;
            $display("FAIL noskid_comb_rdy: rdy=%b dat=%h, want 0 11", c_rdy_o, c_dat_o);
        end
        tick();
        n_checks++;
        if (c_dat_o !== 32'h11 || c_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL noskid_stall: dat=%h cnt=%0d, want 11 1", c_dat_o, c_cnt);
        end
        c_rdy_i = 1'b1;
        #1;
        n_checks++;
        if (c_rdy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL noskid_rdy_up: rdy=%b, want 1", c_rdy_o);
        end
        tick();
        n_checks++;
        if (c_vld_o !== 1'b1 || c_dat_o !== 32'h22) begin
            n_fail++;
            $display("FAIL noskid_b2b_1: vld=%b dat=%h, want 1 22", c_vld_o, c_dat_o);
        end
        c_dat_i = 32'h33;
        tick();
        n_checks++;
        if (c_vld_o !== 1'b1 || c_dat_o !== 32'h33) begin
            n_fail++;
            $display("FAIL noskid_b2b_2: vld=%b dat=%h, want 1 33", c_vld_o, c_dat_o);
        end
        c_flush = 1'b1; c_dat_i = 32'h44;
        tick();
        c_flush = 1'b0; c_vld_i = 1'b0;
        n_checks++;
        if (c_vld_o !== 1'b0 || c_dat_o !== 32'h0 || c_rdy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL noskid_flush: vld=%b dat=%h rdy=%b, want 0 0 1", c_vld_o, c_dat_o, c_rdy_o);
        end
    endtask

    initial begin
        rst = 1'b1; vld_i = 1'b0; rdy_i = 1'b0; flush = 1'b0; clr = 1'b0; dat_i = '0;
        c_vld_i = 1'b0; c_rdy_i = 1'b0; c_flush = 1'b0; c_clr = 1'b0; c_dat_i = '0;
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_saturation();
        test_noskid();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register carrying an opaque payload bus between two RV32I pipeline stages. It adds a valid/ready handshake, an optional skid buffer and a synchronous flush. It also keeps a saturating stall-cycle counter for performance monitoring. It replaces fixed per-stage register banks: decode→execute, execute→memory and memory→writeback are each built from one instance with a different DATA_W.

## Interface
- DATA_W, 160: payload width in bits. Must be ≥ 1. The payload is concatenated control and data fields (rd addr, rs1/rs2, pc, imm, ...).
- SKID_EN, 1: 1 selects a two-entry stage with a main and a skid register, and ready_out is registered. 0 selects a one-entry stage, and ready_out is combinational.
- CLEAR_ON_FLUSH, 1: 1 zeroes the payload registers on flush. 0 leaves their contents unchanged and only drops valid.
- CNT_W, 16: stall counter width. Must be ≥ 1.

Ports:
- clk_in  input  1  clock. All state updates on the rising edge.
- rst_in  input  1  reset. Synchronous, active-high.
- valid_in  input  1  upstream payload valid.
- data_in  input  DATA_W  upstream payload.
- ready_out  output  1  stage can accept data_in this cycle.
- valid_out  output  1  data_out holds a live instruction.
- data_out  output  DATA_W  payload to the downstream stage. Driven directly from the main register.
- ready_in  input  1  downstream accepts data_out this cycle.
- flush_in  input  1  kill all held entries, e.g. on a branch mispredict or trap.
- stall_clr_in  input  1  clear the stall counter.
- stall_cnt_out  output  CNT_W  saturating count of stalled cycles.

## Operation
- Definitions:
  - accept = valid_in & ready_out
  - drain = valid_out & ready_in
- States: EMPTY, FULL (main register valid), SKID (main and skid registers both valid; exists only when SKID_EN=1).
- valid_out = (state != EMPTY).
- SKID_EN=1 transitions:
  - EMPTY: accept → main ← data_in, go to FULL. Otherwise stay.
  - FULL, accept & ready_in: main ← data_in, stay in FULL.
  - FULL, accept & !ready_in: skid ← data_in, go to SKID.
  - FULL, !accept & ready_in: go to EMPTY.
  - FULL, !accept & !ready_in: hold.
  - SKID: ready_in → main ← skid, go to FULL. Otherwise hold. No accept is possible in SKID.
  - ready_out is a register, set to 1 when next state != SKID.
- SKID_EN=0:
  - ready_out = !valid_out | ready_in (combinational).
  - accept loads main and the next state is FULL.
  - drain without accept gives EMPTY.
- Flush:
  - flush_in overrides everything. Next state is EMPTY and ready_out becomes 1.
  - A same-cycle valid_in is dropped, not captured.
  - A same-cycle drain still counts as delivered downstream; the stage does not retract it.
  - With CLEAR_ON_FLUSH=1, main and skid are zeroed. With CLEAR_ON_FLUSH=0, they keep their old values.
- Ordering: payload order is strictly FIFO. The skid entry is never overtaken by data_in.
- data_out is stable while valid_out & !ready_in.
- Stall counter:
  - Increments by 1 in each cycle where valid_out & !ready_in.
  - Saturates at 2^CNT_W−1; it does not wrap.
  - stall_clr_in takes priority over increment and zeroes the counter next cycle.
  - flush_in does not affect the counter.
- Reset: state EMPTY, valid_out 0, data_out 0, skid register 0, stall_cnt_out 0, ready_out 1.
  - Inputs are ignored during reset.
  - Reset asserted mid-transfer discards both entries.

## Timing
- Latency: data accepted at edge N appears on data_out after edge N with valid_out=1. This is 1-cycle latency from EMPTY.
- Throughput: 1 transfer per cycle when ready_in is held high, in both modes.
- SKID_EN=1: ready_out has no combinational path from ready_in or valid_in.
  - Upstream may present one more beat after downstream stalls. That beat lands in the skid register.
- SKID_EN=0: combinational path from ready_in to ready_out; there is no path from data_in to data_out.
- Flush at edge N: valid_out=0 and ready_out=1 from edge N onward.
- stall_cnt_out is updated at the same edge as the state, and reflects cycles up to and including the previous cycle.

## Test plan
- Streaming (SKID_EN=1, DATA_W=32): ready_in=1, feed 0x1..0x8 back-to-back → data_out shows 0x1..0x8 on 8 consecutive cycles starting 1 cycle after the first accept. ready_out stays 1. stall_cnt_out=0.
- Backpressure/skid: load 0xA, then drop ready_in while presenting 0xB → state SKID, ready_out=0 next cycle, data_out holds 0xA. Raise ready_in → 0xA then 0xB delivered in order, ready_out returns to 1. stall_cnt_out equals the number of low-ready_in cycles with valid_out=1.
- Flush in SKID with valid_in=1 and data 0xC → next cycle valid_out=0, ready_out=1, data_out=0 (CLEAR_ON_FLUSH=1). 0xC is never output. Repeat with CLEAR_ON_FLUSH=0 → data_out keeps 0xA, valid_out=0.
- SKID_EN=0: ready_in=0 with the stage FULL → ready_out=0 in the same cycle. Simultaneous accept and drain → new payload on data_out next cycle, no bubble.
- Counter saturation, CNT_W=3: stall 10 cycles → stall_cnt_out sticks at 7. stall_clr_in in the same cycle as a stall → next value 0.
- Reset mid-operation: assert rst_in while in SKID → next cycle valid_out=0, ready_out=1, data_out=0, stall_cnt_out=0. The first beat after reset is delivered normally.
